// File: rtl/ysyx_25030093_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto one memory port, one transaction outstanding.
// Define YSYX_25030093_ARB_RR_EN for round-robin tie-breaking; fixed LSU priority otherwise.
module ysyx_25030093_mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [31:0]       ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [31:0]       lsu_wdata,
   input  logic [3:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [31:0]       lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

   state_e            state_q, state_d;
   logic              win_lsu_q, win_lsu_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic              prio_lsu;
   logic              grant_lsu, grant_ifu;
   logic              resp_rdy;

`ifdef YSYX_25030093_ARB_RR_EN
   logic last_lsu_q, last_lsu_d;
   // Tie goes to whoever was not granted last; resets to "LSU last" so IFU wins first.
   assign prio_lsu = ~last_lsu_q;
`else
   assign prio_lsu = 1'b1;
`endif

   // Grant depends only on request valids and the pointer, never on memory handshakes.
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | prio_lsu);
   assign grant_ifu = ifu_req_valid & ~grant_lsu;

   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;

   always_comb begin
      state_d        = state_q;
      win_lsu_d      = win_lsu_q;
      addr_d         = addr_q;
      wen_d          = wen_q;
      wdata_d        = wdata_q;
      wmask_d        = wmask_q;
`ifdef YSYX_25030093_ARB_RR_EN
      last_lsu_d     = last_lsu_q;
`endif
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = 32'h0;
      lsu_rdata      = 32'h0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
      resp_rdy       = win_lsu_q ? lsu_resp_ready : ifu_resp_ready;
      case (state_q)
         S_IDLE: begin
            ifu_req_ready = grant_ifu & ~reset;
            lsu_req_ready = grant_lsu & ~reset;
            if (grant_lsu) begin
               state_d   = S_REQ;
               win_lsu_d = 1'b1;
               addr_d    = lsu_addr;
               wen_d     = lsu_wen;
               wdata_d   = lsu_wdata;
               wmask_d   = lsu_wmask;
`ifdef YSYX_25030093_ARB_RR_EN
               last_lsu_d = 1'b1;
`endif
            end else if (grant_ifu) begin
               state_d   = S_REQ;
               win_lsu_d = 1'b0;
               addr_d    = ifu_addr;
               wen_d     = 1'b0;
               wdata_d   = 32'h0;
               wmask_d   = 4'h0;
`ifdef YSYX_25030093_ARB_RR_EN
               last_lsu_d = 1'b0;
`endif
            end
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = S_RESP;
         end
         S_RESP: begin
            mem_resp_ready = resp_rdy;
            if (win_lsu_q) begin
               lsu_resp_valid = mem_resp_valid;
               lsu_rdata      = mem_rdata;
            end else begin
               ifu_resp_valid = mem_resp_valid;
               ifu_rdata      = mem_rdata;
            end
            if (mem_resp_valid && resp_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         win_lsu_q <= 1'b0;
         addr_q    <= '0;
         wen_q     <= 1'b0;
         wdata_q   <= 32'h0;
         wmask_q   <= 4'h0;
`ifdef YSYX_25030093_ARB_RR_EN
         last_lsu_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         win_lsu_q <= win_lsu_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
`ifdef YSYX_25030093_ARB_RR_EN
         last_lsu_q <= last_lsu_d;
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Directed bench for ysyx_25030093_mem_arbiter in its default (fixed LSU priority) build.
module tb_ysyx_25030093_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int n_chk = 0;
   int n_err = 0;

   ysyx_25030093_mem_arbiter #(.ADDR_W(32)) dut (
      .clock(clock), .reset(reset),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Memory accepts at once and answers with rdata on the following cycle.
   task automatic serve(input logic [31:0] rdata);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = rdata;
      step();
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'h0;
   endtask

   initial begin
      reset = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = 32'h0; ifu_resp_ready = 1'b1;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0;
      lsu_wmask = 4'h0; lsu_resp_ready = 1'b1;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      step();
      chk("rst_ifu_req_ready", 32'(ifu_req_ready), 0);
      chk("rst_lsu_req_ready", 32'(lsu_req_ready), 0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
      chk("rst_mem_addr", mem_addr, 0);
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      step();
      reset = 1'b0;
      step();

      // IFU-only read
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      #1;
      chk("ifu_only_ready", 32'(ifu_req_ready), 1);
      chk("ifu_only_lsu_ready", 32'(lsu_req_ready), 0);
      step();
      ifu_req_valid = 1'b0; ifu_addr = 32'h1234_5678;
      chk("ifu_req_valid_out", 32'(mem_req_valid), 1);
      chk("ifu_req_addr", mem_addr, 32'h8000_0000);
      chk("ifu_req_wen", 32'(mem_wen), 0);
      chk("ifu_req_wmask", 32'(mem_wmask), 0);
      chk("ifu_req_wdata", mem_wdata, 0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("ifu_resp_state_no_req", 32'(mem_req_valid), 0);
      mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
      #1;
      chk("ifu_resp_valid", 32'(ifu_resp_valid), 1);
      chk("ifu_rdata", ifu_rdata, 32'h0000_0413);
      chk("ifu_lsu_resp_valid", 32'(lsu_resp_valid), 0);
      chk("ifu_lsu_rdata", lsu_rdata, 0);
      chk("ifu_mem_resp_ready", 32'(mem_resp_ready), 1);
      step();
      mem_resp_valid = 1'b0;
      chk("ifu_done_resp_valid", 32'(ifu_resp_valid), 0);

      // Simultaneous requests: LSU first, IFU next
      ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0200;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0100; lsu_wen = 1'b0;
      #1;
      chk("tie_lsu_ready", 32'(lsu_req_ready), 1);
      chk("tie_ifu_ready", 32'(ifu_req_ready), 0);
      step();
      lsu_req_valid = 1'b0;
      chk("tie_mem_addr_lsu", mem_addr, 32'h0000_0100);
      chk("tie_ifu_ready_busy", 32'(ifu_req_ready), 0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 32'hA5A5_0001;
      #1;
      chk("tie_lsu_resp_valid", 32'(lsu_resp_valid), 1);
      chk("tie_lsu_rdata", lsu_rdata, 32'hA5A5_0001);
      chk("tie_ifu_resp_valid", 32'(ifu_resp_valid), 0);
      chk("tie_ifu_rdata", ifu_rdata, 0);
      step();
      mem_resp_valid = 1'b0;
      chk("tie_ifu_ready_next", 32'(ifu_req_ready), 1);
      step();
      ifu_req_valid = 1'b0;
      chk("tie_mem_addr_ifu", mem_addr, 32'h0000_0200);
      serve(32'h1111_2222);

      // LSU write with memory stalling three cycles
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      step();
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      for (int i = 0; i < 4; i++) begin
         chk("wr_req_valid", 32'(mem_req_valid), 1);
         chk("wr_addr", mem_addr, 32'h8000_1000);
         chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
         chk("wr_wmask", 32'(mem_wmask), 32'hF);
         chk("wr_wen", 32'(mem_wen), 1);
         if (i == 3) mem_req_ready = 1'b1;
         step();
      end
      mem_req_ready = 1'b0;
      chk("wr_req_dropped", 32'(mem_req_valid), 0);
      mem_resp_valid = 1'b1;
      #1;
      chk("wr_ack", 32'(lsu_resp_valid), 1);
      step();
      mem_resp_valid = 1'b0;

      // IFU response backpressure for two cycles
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
      step();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      ifu_resp_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0093;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("bp_mem_resp_ready", 32'(mem_resp_ready), 0);
         chk("bp_ifu_resp_valid", 32'(ifu_resp_valid), 1);
         step();
      end
      ifu_resp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(mem_resp_ready), 1);
      chk("bp_rdata", ifu_rdata, 32'h0010_0093);
      step();
      chk("bp_done", 32'(ifu_resp_valid), 0);
      mem_resp_valid = 1'b0;

      // Reset asserted mid-response
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
      step();
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      ifu_resp_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("pre_rst_resp_valid", 32'(ifu_resp_valid), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_ifu_resp_valid", 32'(ifu_resp_valid), 0);
      chk("arst_ifu_rdata", ifu_rdata, 0);
      chk("arst_mem_resp_ready", 32'(mem_resp_ready), 0);
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_req_valid", 32'(mem_req_valid), 0);
      ifu_resp_ready = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("post_rst_no_stale", 32'(ifu_resp_valid), 0);
      mem_resp_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_000C;
      #1;
      chk("post_rst_grant", 32'(ifu_req_ready), 1);
      step();
      ifu_req_valid = 1'b0;
      chk("post_rst_req_valid", 32'(mem_req_valid), 1);
      chk("post_rst_addr", mem_addr, 32'h8000_000C);
      serve(32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
